// File: rtl/write_sink_avalon.sv
// Write sink: buffers solver pixel writes in a small FIFO and drains them
// as Avalon-MM master writes into the frame buffer.
//
// Ports
//   clock, reset      single clock, synchronous active-high reset
//   in_data/in_addr   pixel value and 16-bit word index from the arbitrator
//   in_write_en       request valid, held until in_ack is seen
//   in_ack            one-cycle pulse, request accepted into the FIFO
//   avm_*             Avalon-MM master write port (16-bit data)
//   fifo_count        entries currently buffered
//   idle              FIFO empty and no Avalon write outstanding
//   writes_done       completed Avalon writes, wraps at 2^32
module write_sink_avalon #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [15:0]                   in_data,
    input  logic [31:0]                   in_addr,
    input  logic                          in_write_en,
    output logic                          in_ack,
    output logic [31:0]                   avm_address,
    output logic [15:0]                   avm_writedata,
    output logic [1:0]                    avm_byteenable,
    output logic                          avm_write,
    input  logic                          avm_waitrequest,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle,
    output logic [31:0]                   writes_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t state;

    // in_addr[31] never reaches the bus, so only 31 address bits are kept.
    logic [46:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          armed;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [46:0]   head;

    assign avm_byteenable = 2'b11;
    assign not_empty      = (fifo_count != '0);
    assign head           = mem[rd_ptr];
    assign idle           = !not_empty && (state == ST_IDLE);

    // Full test uses the pre-edge count: a same-edge pop never makes room.
    assign push = in_write_en && armed && (fifo_count != FULL);

    always_comb begin
        pop = 1'b0;
        unique case (state)
            ST_IDLE:  pop = not_empty;
            ST_WRITE: pop = not_empty && !avm_waitrequest;
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_addr[30:0], in_data};
        end
    end

    // Accept side. armed blocks a second push while the requester still
    // holds write_en during the ack cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ack     <= 1'b0;
            armed      <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            in_ack <= push;
            if (push) begin
                armed  <= 1'b0;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (!in_write_en) begin
                armed <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Master FSM: loads the FIFO head onto the bus and keeps writing
    // back-to-back while entries remain.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            writes_done   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        avm_address   <= ADDR_BASE + {head[46:16], 1'b0};
                        avm_writedata <= head[15:0];
                        avm_write     <= 1'b1;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        writes_done <= writes_done + 32'd1;
                        if (pop) begin
                            avm_address   <= ADDR_BASE + {head[46:16], 1'b0};
                            avm_writedata <= head[15:0];
                        end else begin
                            avm_write <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    avm_write <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_sink_avalon.sv
// Directed and randomized bench for write_sink_avalon.
// Second instance covers a wrapping ADDR_BASE.
module tb_write_sink_avalon;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [31:0] in_addr = '0;
    logic        in_write_en = 1'b0;
    logic        avm_waitrequest = 1'b0;

    logic        in_ack, avm_write, idle;
    logic [31:0] avm_address, writes_done;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic [2:0]  fifo_count;

    logic        w_in_ack, w_avm_write, w_idle;
    logic [31:0] w_avm_address, w_writes_done;
    logic [15:0] w_avm_writedata;
    logic [1:0]  w_avm_byteenable;
    logic [2:0]  w_fifo_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cnt  = 0;

    logic [47:0] wr_log[$];
    int          wr_cyc[$];
    logic [47:0] exp_q[$];

    always #5 clock = ~clock;

    write_sink_avalon #(.FIFO_DEPTH(4), .ADDR_BASE(32'h0)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_addr(in_addr),
        .in_write_en(in_write_en), .in_ack(in_ack),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_write(avm_write),
        .avm_waitrequest(avm_waitrequest), .fifo_count(fifo_count),
        .idle(idle), .writes_done(writes_done)
    );

    write_sink_avalon #(.FIFO_DEPTH(4), .ADDR_BASE(32'hFFFF_FFF0)) u_wrap (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_addr(in_addr),
        .in_write_en(in_write_en), .in_ack(w_in_ack),
        .avm_address(w_avm_address), .avm_writedata(w_avm_writedata),
        .avm_byteenable(w_avm_byteenable), .avm_write(w_avm_write),
        .avm_waitrequest(avm_waitrequest), .fifo_count(w_fifo_count),
        .idle(w_idle), .writes_done(w_writes_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: log a completing Avalon write, then sample after the edge.
    task automatic tick();
        if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
            wr_log.push_back({avm_address, avm_writedata});
            wr_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (in_ack === 1'b1) ack_cnt++;
    endtask

    // Arbitrator-style request: hold until ack, then drop for one cycle.
    task automatic req(input logic [31:0] a, input logic [15:0] d,
                       input int max, output bit got);
        in_addr = a;
        in_data = d;
        in_write_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (in_ack) got = 1'b1;
        end
        in_write_en = 1'b0;
        tick();
    endtask

    initial begin
        bit got;
        int a0, n0, gap, wd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ack", in_ack, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_idle", idle, 1);
        chk("rst_done", writes_done, 0);
        chk("rst_be", avm_byteenable, 2'b11);
        reset = 1'b0;
        tick();

        // 1: single write
        in_addr = 32'd5;
        in_data = 16'hBEEF;
        in_write_en = 1'b1;
        tick();
        chk("t1_ack", in_ack, 1);
        chk("t1_count1", fifo_count, 1);
        in_write_en = 1'b0;
        tick();
        chk("t1_ack_drop", in_ack, 0);
        chk("t1_write", avm_write, 1);
        chk("t1_addr", avm_address, 32'h0A);
        chk("t1_data", avm_writedata, 16'hBEEF);
        tick();
        chk("t1_write_end", avm_write, 0);
        chk("t1_done", writes_done, 1);
        chk("t1_idle", idle, 1);
        chk("t1_log", wr_log.size(), 1);

        // 2: write_en stuck high for 10 cycles
        a0 = ack_cnt;
        in_addr = 32'd7;
        in_data = 16'h1234;
        in_write_en = 1'b1;
        repeat (10) tick();
        in_write_en = 1'b0;
        repeat (3) tick();
        chk("t2_acks", ack_cnt - a0, 1);
        chk("t2_done", writes_done, 2);
        chk("t2_log_n", wr_log.size(), 2);
        chk("t2_log", wr_log[1], {32'h0E, 16'h1234});

        // 3: backpressure, depth 4
        avm_waitrequest = 1'b1;
        n0 = wr_log.size();
        for (int i = 0; i < 5; i++) begin
            req(32'd100 + 32'(i), 16'hA000 + 16'(i), 4, got);
            chk("t3_ack", got, 1);
        end
        chk("t3_full", fifo_count, 4);
        chk("t3_busy", avm_write, 1);
        chk("t3_head", avm_address, 32'd200);
        a0 = ack_cnt;
        in_addr = 32'd105;
        in_data = 16'hA005;
        in_write_en = 1'b1;
        repeat (5) tick();
        chk("t3_pending", ack_cnt - a0, 0);
        chk("t3_still4", fifo_count, 4);
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (in_ack) in_write_en = 1'b0;
            if (wr_log.size() >= n0 + 6 && idle) break;
        end
        chk("t3_ack6", ack_cnt - a0, 1);
        chk("t3_n", wr_log.size(), n0 + 6);
        if (wr_log.size() >= n0 + 6) begin
            for (int i = 0; i < 6; i++)
                chk("t3_order", wr_log[n0+i],
                    {32'd200 + 32'(2*i), 16'hA000 + 16'(i)});
            chk("t3_b2b", wr_cyc[n0+5] - wr_cyc[n0], 5);
        end
        chk("t3_done", writes_done, 8);

        // 4: base offset and address wrap
        in_addr = 32'd16;
        in_data = 16'h5555;
        in_write_en = 1'b1;
        tick();
        in_write_en = 1'b0;
        tick();
        chk("t4_wrap_addr", w_avm_address, 32'h0000_0010);
        chk("t4_wrap_write", w_avm_write, 1);
        chk("t4_base0_addr", avm_address, 32'h20);
        tick();
        in_addr = 32'h8000_0003;
        in_data = 16'h7777;
        in_write_en = 1'b1;
        tick();
        in_write_en = 1'b0;
        tick();
        chk("t4_msb_drop", avm_address, 32'h6);
        chk("t4_msb_data", avm_writedata, 16'h7777);
        repeat (2) tick();

        // 5: reset in the middle of a stalled burst
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++)
            req(32'd300 + 32'(i), 16'hC000 + 16'(i), 4, got);
        chk("t5_queued", fifo_count, 3);
        chk("t5_busy", avm_write, 1);
        reset = 1'b1;
        tick();
        chk("t5_write", avm_write, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_done", writes_done, 0);
        chk("t5_idle", idle, 1);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        tick();
        n0 = wr_log.size();
        req(32'd9, 16'h0909, 4, got);
        chk("t5_new_ack", got, 1);
        repeat (3) tick();
        chk("t5_new_n", wr_log.size(), n0 + 1);
        if (wr_log.size() > n0)
            chk("t5_new_wr", wr_log[n0], {32'd18, 16'h0909});
        chk("t5_new_done", writes_done, 1);

        // 6: random requests and backpressure against a scoreboard
        wr_log.delete();
        wr_cyc.delete();
        exp_q.delete();
        a0 = ack_cnt;
        wd0 = int'(writes_done);
        gap = 0;
        for (int c = 0; c < 4000; c++) begin
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            if (!in_write_en && gap == 0 && $urandom_range(0, 1) == 1) begin
                in_addr = $urandom;
                in_data = 16'($urandom);
                in_write_en = 1'b1;
                exp_q.push_back({{in_addr[30:0], 1'b0}, in_data});
            end
            tick();
            if (gap > 0) gap--;
            if (in_ack) begin
                in_write_en = 1'b0;
                gap = 1;
            end
        end
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!in_write_en && idle) break;
            tick();
            if (in_ack) in_write_en = 1'b0;
        end
        chk("t6_drained", {in_write_en, idle}, 2'b01);
        chk("t6_acks", ack_cnt - a0, exp_q.size());
        chk("t6_writes", wr_log.size(), exp_q.size());
        chk("t6_done", int'(writes_done) - wd0, exp_q.size());
        if (wr_log.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                chk("t6_entry", wr_log[i], exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
